// File: rtl/my_pc_stack.sv
// my_pc_stack: program counter with a DEPTH-entry hardware return-address stack.
// One command per cycle: reset > ret > call > load > rel > inc > hold.
// Sticky overflow/underflow flags record rejected call/ret. All outputs are registered.
module my_pc_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             rel,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic [SW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]    depth_q, depth_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  // Stack storage: never reset, contents only reachable through a valid pop.
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push_en;
  logic [IW-1:0]    push_idx;
  logic [WIDTH-1:0] push_data;
  logic             ovf_evt, unf_evt;
  logic             is_empty, is_full;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == SW'(DEPTH));

  // Next-state: prioritised command decode, stack push request and flag update.
  always_comb begin
    out_d     = out_q;
    depth_d   = depth_q;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    push_en   = 1'b0;
    push_idx  = IW'(depth_q);
    push_data = out_q + WIDTH'(1);
    if (ret) begin
      if (is_empty) unf_evt = 1'b1;
      else begin
        out_d   = stack_q[IW'(depth_q - SW'(1))];
        depth_d = depth_q - SW'(1);
      end
    end else if (call) begin
      if (is_full) ovf_evt = 1'b1;
      else begin
        push_en = 1'b1;
        depth_d = depth_q + SW'(1);
        out_d   = in;
      end
    end else if (load) begin
      out_d = in;
    end else if (rel) begin
      out_d = out_q + in;
    end else if (inc) begin
      out_d = out_q + WIDTH'(1);
    end
    // Set wins over clear when both happen in the same cycle.
    err_ovf_d = (err_ovf_q & ~clr_err) | ovf_evt;
    err_unf_d = (err_unf_q & ~clr_err) | unf_evt;
  end

  // PC, depth and sticky flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q     <= '0;
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // Return-address write; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && push_en) stack_q[push_idx] <= push_data;
  end

  assign out     = out_q;
  assign depth   = depth_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_my_pc_stack.sv
// Scoreboard bench for my_pc_stack (WIDTH=16, DEPTH=4): directed scenarios then
// random commands; a queue-based LIFO model predicts each cycle's outputs.
module tb_my_pc_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, load, rel, inc, call, ret, clr_err;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [SW-1:0]    depth;
  logic             empty, full, err_ovf, err_unf;

  my_pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .rel(rel), .inc(inc),
    .call(call), .ret(ret), .clr_err(clr_err), .out(out), .depth(depth),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pc;
    int               dep;
    logic             emp, ful, ovf, unf;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_stk[$];
  logic [WIDTH-1:0] m_pc;
  logic             m_ovf, m_unf;
  int               n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one command on the falling edge and push the model's prediction.
  task automatic cmd(input logic rs, input logic rt, input logic cl, input logic ld,
                     input logic rl, input logic ic, input logic ce, input logic [WIDTH-1:0] d);
    exp_t e;
    logic oe, ue;
    @(negedge clk);
    reset = rs; ret = rt; call = cl; load = ld; rel = rl; inc = ic; clr_err = ce; in = d;
    oe = 1'b0; ue = 1'b0;
    if (!rs) begin
      m_pc = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (rt) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else ue = 1'b1;
      end else if (cl) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(m_pc + 16'd1);
          m_pc = d;
        end else oe = 1'b1;
      end else if (ld) m_pc = d;
      else if (rl) m_pc = m_pc + d;
      else if (ic) m_pc = m_pc + 16'd1;
      if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
      m_ovf = m_ovf | oe;
      m_unf = m_unf | ue;
    end
    e.pc  = m_pc;
    e.dep = m_stk.size();
    e.emp = (m_stk.size() == 0);
    e.ful = (m_stk.size() == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
  endtask

  task automatic rst();      cmd(0,0,0,0,0,0,0,'0); endtask
  task automatic hold();     cmd(1,0,0,0,0,0,0,'0); endtask
  task automatic do_inc();   cmd(1,0,0,0,0,1,0,'0); endtask
  task automatic do_ld(input logic [WIDTH-1:0] d); cmd(1,0,0,1,0,0,0,d); endtask
  task automatic do_call(input logic [WIDTH-1:0] d); cmd(1,0,1,0,0,0,0,d); endtask
  task automatic do_ret();   cmd(1,1,0,0,0,0,0,'0); endtask
  task automatic do_clr();   cmd(1,0,0,0,0,0,1,'0); endtask

  // Monitor: every cycle the DUT presents new state; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out",     32'(out),     32'(e.pc));
        chk("depth",   32'(depth),   32'(e.dep));
        chk("empty",   32'(empty),   32'(e.emp));
        chk("full",    32'(full),    32'(e.ful));
        chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
        chk("err_unf", 32'(err_unf), 32'(e.unf));
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0; ret = 0; call = 0; load = 0; rel = 0; inc = 0; clr_err = 0; in = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0;
    // Reset, hold, inc x2, load beats inc, load ignored under reset.
    rst(); hold(); do_inc(); do_inc();
    cmd(1,0,0,1,0,1,0,16'h8285);
    cmd(0,0,0,1,0,0,0,16'h1234);
    // Nested call/return.
    do_ld(16'h0010); do_call(16'h0100); do_call(16'h0200); do_ret(); do_ret();
    // Overflow, clear, clear racing a new overflow.
    rst(); do_call(16'h0001); do_call(16'h0002); do_call(16'h0003); do_call(16'h0004);
    do_call(16'h7777); do_clr();
    cmd(1,0,1,0,0,0,1,16'h5555);
    // Underflow; ret beats call and load.
    rst(); do_ret();
    do_call(16'h0abc);
    cmd(1,1,1,1,0,0,0,16'h4444);
    // Relative branch and wraparound.
    do_ld(16'h0005); cmd(1,0,0,0,1,0,0,16'hfffd);
    do_ld(16'hffff); do_inc();
    do_ld(16'hffff); do_call(16'h0040); do_ret();
    // Reset mid-stack with a call pending, then underflow.
    rst(); do_call(16'h0011); do_call(16'h0022); do_call(16'h0033);
    cmd(0,0,1,0,0,0,0,16'h0099); do_ret();
    // Back-to-back call/ret.
    for (int i = 0; i < 6; i++) begin do_call(16'(i * 3 + 7)); do_ret(); end
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'(32'hffff - $urandom_range(0, 7)) : 16'($urandom);
      cmd($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 7) == 0, d);
    end
    hold();
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/my_pc_stack.md
# my_pc_stack

Parametrised program counter with a hardware return-address stack, successor to the 16-bit load/inc/reset PC. Adds configurable width, relative branches, and call/return with a DEPTH-entry LIFO plus sticky overflow/underflow flags. It sits in the CPU fetch path and drives the instruction-memory address every cycle.

## Interface
- WIDTH, 16, width of PC, `in` and stack entries (≥2)
- DEPTH, 8, return-stack entries (≥1)
- SW, $clog2(DEPTH+1), width of `depth` output (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- in  in  WIDTH  absolute target (load, call) or two's-complement offset (rel)
- load  in  1  jump: out ← in
- rel  in  1  relative branch: out ← out + in
- inc  in  1  step: out ← out + 1
- call  in  1  push out+1, then out ← in
- ret  in  1  pop: out ← top of stack
- clr_err  in  1  clear sticky error flags
- out  out  WIDTH  current PC
- depth  out  SW  number of valid stack entries, 0..DEPTH
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- err_ovf  out  1  sticky: call attempted while full
- err_unf  out  1  sticky: ret attempted while empty

## Operation
- One command per cycle, fixed priority: reset (low) > ret > call > load > rel > inc > hold. Lower-priority strobes in the same cycle are ignored.
- reset low: out=0, depth=0, err_ovf=0, err_unf=0. Stack RAM contents not cleared and not observable.
- ret, depth>0: out ← stack[depth-1]; depth ← depth-1.
- ret, depth==0: out holds, depth holds, err_unf ← 1.
- call, depth<DEPTH: stack[depth] ← out+1 (mod 2^WIDTH); depth ← depth+1; out ← in.
- call, depth==DEPTH: no push, out holds, depth holds, err_ovf ← 1.
- load: out ← in. rel: out ← out + in, in treated signed, result mod 2^WIDTH. inc: out ← out+1 mod 2^WIDTH.
- All arithmetic wraps silently: out=2^WIDTH-1 with inc → 0; call from out=2^WIDTH-1 pushes 0.
- Errors: rejected call/ret leave all non-flag state unchanged. Flags remain set until clr_err or reset.
- clr_err: clears both flags; if an error event occurs in the same cycle, the flag is set (set wins).
- empty/full derive combinationally from the registered depth; no combinational path from any input to any output.

## Timing
- All outputs registered; a command sampled at edge N is visible on out/depth/flags immediately after edge N. Latency is 1 cycle. No stalls, no handshake.
- Back-to-back call/ret every cycle is supported; ret in the cycle directly after a call returns the address just pushed.
- Reset is synchronous: asserting it mid-sequence (e.g. stack partially full) takes effect at the next edge regardless of other strobes; inputs during reset are ignored.
- Before the first reset edge, outputs are undefined; the bench must apply reset ≥1 cycle.

## Test plan (WIDTH=16, DEPTH=4)
- Reset then hold; inc×2; load in=0x8285 with inc=1 → out 0, 0, 1, 2, 0x8285 (load beats inc); load=1 with reset low → out 0.
- out=0x0010, call in=0x0100 → out 0x0100, depth 1; call in=0x0200 → out 0x0200, depth 2; ret → 0x0101, depth 1; ret → 0x0011, depth 0, empty 1.
- Four calls from out=0 → depth 4, full 1; fifth call in=0x7777 → out unchanged, depth 4, err_ovf 1; clr_err → err_ovf 0; clr_err together with another call → err_ovf 1.
- From reset, ret → out 0, err_unf 1; call+ret+load same cycle with depth=1 → ret wins, out = popped value, depth 0.
- out=0x0005, rel in=0xFFFD → 0x0002; out=0xFFFF, inc → 0x0000; out=0xFFFF, call in=0x0040 then ret → 0x0000.
- Depth 3 stack, reset low with call=1 → out 0, depth 0, empty 1, flags 0; subsequent ret → err_unf 1.
